// File: rtl/twisted_ring_counter_if.sv
// Control and status bundle for twisted_ring_counter.
// The slave modport is the counter itself; the master modport is whoever drives it.
interface twisted_ring_counter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned PW = $clog2(2 * N);

    logic          i_en;
    logic          i_up;
    logic          i_mode;
    logic          i_load;
    logic [N-1:0]  i_load_val;
    logic [N-1:0]  o_q;
    logic [PW-1:0] o_phase;
    logic          o_wrap;
    logic          o_illegal;

    modport master (
        output i_en,
        output i_up,
        output i_mode,
        output i_load,
        output i_load_val,
        input  o_q,
        input  o_phase,
        input  o_wrap,
        input  o_illegal
    );

    modport slave (
        input  i_en,
        input  i_up,
        input  i_mode,
        input  i_load,
        input  i_load_val,
        output o_q,
        output o_phase,
        output o_wrap,
        output o_illegal
    );
endinterface

// File: rtl/twisted_ring_counter.sv
// Johnson/ring shift counter with direction, load, self-correction, wrap pulse and phase decode.
// Reset is synchronous and active-low.
module twisted_ring_counter #(
    parameter int unsigned N = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    twisted_ring_counter_if.slave   bus
);
    localparam int unsigned PW = $clog2(2 * N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0]  r_q;
    logic          r_wrap;
    logic          r_illegal;

    logic [N-1:0]  w_start;
    logic [N-1:0]  w_step;
    logic [N-1:0]  w_q_next;
    logic          w_wrap_next;
    logic          w_illegal_next;
    logic          w_cur_legal;
    logic          w_load_legal;
    logic [PW-1:0] w_phase;
    int unsigned   w_ones;

    // Johnson-legal patterns are 0..01..1 or 1..10..0; each side is a 2^k-1 test.
    function automatic logic f_legal(input logic [N-1:0] v, input logic mode);
        logic [N-1:0] nv;
        nv = ~v;
        if (mode) begin
            return $onehot(v);
        end
        return ((v & (v + ONE)) == '0) || ((nv & (nv + ONE)) == '0);
    endfunction

    function automatic logic [N-1:0] f_step(input logic [N-1:0] v, input logic up,
                                             input logic mode);
        logic [N-1:0] s;
        if (up) begin
            s = {v[N-2:0], (mode ? v[N-1] : ~v[N-1])};
        end else begin
            s = {(mode ? v[0] : ~v[0]), v[N-1:1]};
        end
        return s;
    endfunction

    assign w_start      = bus.i_mode ? ONE : '0;
    assign w_cur_legal  = f_legal(r_q, bus.i_mode);
    assign w_load_legal = f_legal(bus.i_load_val, bus.i_mode);
    assign w_step       = f_step(r_q, bus.i_up, bus.i_mode);

    always_comb begin
        w_q_next       = r_q;
        w_wrap_next    = 1'b0;
        w_illegal_next = 1'b0;
        if (bus.i_load) begin
            if (w_load_legal) begin
                w_q_next = bus.i_load_val;
            end else begin
                w_q_next       = w_start;
                w_illegal_next = 1'b1;
            end
        end else if (bus.i_en) begin
            if (!w_cur_legal) begin
                w_q_next       = w_start;
                w_illegal_next = 1'b1;
            end else begin
                w_q_next    = w_step;
                w_wrap_next = (w_step == w_start);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q       <= w_start;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_wrap    <= w_wrap_next;
            r_illegal <= w_illegal_next;
        end
    end

    // Phase: set-bit index in ring mode; ones count, or 2N minus ones once the MSB is set.
    always_comb begin
        w_phase = '0;
        w_ones  = 0;
        for (int i = 0; i < int'(N); i++) begin
            w_ones = w_ones + {31'd0, r_q[i]};
        end
        if (w_cur_legal) begin
            if (bus.i_mode) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (r_q[i]) begin
                        w_phase = PW'(i);
                    end
                end
            end else if (!r_q[N-1]) begin
                w_phase = PW'(w_ones);
            end else begin
                w_phase = PW'(2 * N - w_ones);
            end
        end
    end

    assign bus.o_q       = r_q;
    assign bus.o_phase   = w_phase;
    assign bus.o_wrap    = r_wrap;
    assign bus.o_illegal = r_illegal;
endmodule

// File: tb/tb_twisted_ring_counter.sv
// Scoreboard bench for twisted_ring_counter at N=4 and N=32, driven from a sequence-table model.
module tb_twisted_ring_counter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    twisted_ring_counter_if #(.N(4))  bus4 ();
    twisted_ring_counter_if #(.N(32)) bus32 ();

    twisted_ring_counter #(.N(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    twisted_ring_counter #(.N(32)) dut32 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus32)
    );

    typedef struct {
        logic [31:0] q;
        int          phase;
        bit          wrap;
        bit          illegal;
    } exp_t;

    exp_t        sb4[$];
    exp_t        sb32[$];
    logic [31:0] m_q4;
    logic [31:0] m_q32;
    bit          m_valid = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          wraps32 = 0;

    // k-th pattern of the sequence that starts at START.
    function automatic logic [31:0] seq_val(input int k, input int n, input bit mode);
        logic [63:0] full;
        logic [63:0] v;
        full = (64'd1 << n) - 64'd1;
        if (mode)        v = 64'd1 << k;
        else if (k <= n) v = (64'd1 << k) - 64'd1;
        else             v = full ^ ((64'd1 << (k - n)) - 64'd1);
        return v[31:0];
    endfunction

    function automatic int seq_len(input int n, input bit mode);
        return mode ? n : 2 * n;
    endfunction

    function automatic int seq_idx(input logic [31:0] q, input int n, input bit mode);
        for (int k = 0; k < seq_len(n, mode); k++) begin
            if (seq_val(k, n, mode) === q) return k;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [31:0] cur, input int n, input bit rstn, input bit en,
                              input bit up, input bit mode, input bit load,
                              input logic [31:0] lv, output exp_t e);
        int idx;
        int len;
        len       = seq_len(n, mode);
        e.wrap    = 1'b0;
        e.illegal = 1'b0;
        if (!rstn) begin
            e.q = seq_val(0, n, mode);
        end else if (load) begin
            if (seq_idx(lv, n, mode) >= 0) begin
                e.q = lv;
            end else begin
                e.q       = seq_val(0, n, mode);
                e.illegal = 1'b1;
            end
        end else if (en) begin
            idx = seq_idx(cur, n, mode);
            if (idx < 0) begin
                e.q       = seq_val(0, n, mode);
                e.illegal = 1'b1;
            end else begin
                idx    = up ? (idx + 1) % len : (idx + len - 1) % len;
                e.q    = seq_val(idx, n, mode);
                e.wrap = (idx == 0);
            end
        end else begin
            e.q = cur;
        end
        idx     = seq_idx(e.q, n, mode);
        e.phase = (idx < 0) ? 0 : idx;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drives one cycle of stimulus at the falling edge and queues the expected post-edge state.
    task automatic drive(input bit rstn, input bit en, input bit up, input bit mode, input bit load,
                         input logic [31:0] lv4, input logic [31:0] lv32);
        exp_t e4;
        exp_t e32;
        @(negedge clk);
        rst_n            = rstn;
        bus4.i_en        = en;
        bus4.i_up        = up;
        bus4.i_mode      = mode;
        bus4.i_load      = load;
        bus4.i_load_val  = lv4[3:0];
        bus32.i_en       = en;
        bus32.i_up       = up;
        bus32.i_mode     = mode;
        bus32.i_load     = load;
        bus32.i_load_val = lv32;
        #1;
        if (m_valid) begin
            check("pre_edge_q4", 64'(bus4.o_q), 64'(m_q4));
            check("pre_edge_q32", 64'(bus32.o_q), 64'(m_q32));
        end
        model_step(m_q4, 4, rstn, en, up, mode, load, {28'd0, lv4[3:0]}, e4);
        model_step(m_q32, 32, rstn, en, up, mode, load, lv32, e32);
        sb4.push_back(e4);
        sb32.push_back(e32);
        m_q4    = e4.q;
        m_q32   = e32.q;
        m_valid = 1'b1;
    endtask

    task automatic run(input bit en, input bit up, input bit mode, input int cycles);
        for (int i = 0; i < cycles; i++) drive(1'b1, en, up, mode, 1'b0, 32'd0, 32'd0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb4.size() > 0) begin
            e = sb4.pop_front();
            check("q4", 64'(bus4.o_q), 64'(e.q));
            check("phase4", 64'(bus4.o_phase), 64'(e.phase));
            check("wrap4", 64'(bus4.o_wrap), 64'(e.wrap));
            check("illegal4", 64'(bus4.o_illegal), 64'(e.illegal));
        end
        if (sb32.size() > 0) begin
            e = sb32.pop_front();
            check("q32", 64'(bus32.o_q), 64'(e.q));
            check("phase32", 64'(bus32.o_phase), 64'(e.phase));
            check("wrap32", 64'(bus32.o_wrap), 64'(e.wrap));
            check("illegal32", 64'(bus32.o_illegal), 64'(e.illegal));
        end
        if (bus32.o_wrap === 1'b1) wraps32++;
    end

    initial begin
        bit          mode;
        bit          load;
        logic [31:0] lv4;
        logic [31:0] lv32;
        rst_n            = 1'b0;
        bus4.i_en        = 1'b0;
        bus4.i_up        = 1'b0;
        bus4.i_mode      = 1'b0;
        bus4.i_load      = 1'b0;
        bus4.i_load_val  = '0;
        bus32.i_en       = 1'b0;
        bus32.i_up       = 1'b0;
        bus32.i_mode     = 1'b0;
        bus32.i_load     = 1'b0;
        bus32.i_load_val = '0;

        // Johnson up: full period plus one
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        run(1'b1, 1'b1, 1'b0, 9);
        // Johnson down with an enable gap
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run(1'b1, 1'b0, 1'b0, 4);
        run(1'b0, 1'b0, 1'b0, 3);
        run(1'b1, 1'b0, 1'b0, 4);
        // Ring down from START, then up
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0);
        run(1'b1, 1'b0, 1'b1, 1);
        run(1'b1, 1'b1, 1'b1, 5);
        // Loads in Johnson mode
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h5, 32'h5);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h7, 32'h7);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3, 32'h3);
        // Mode switch on a Johnson-only pattern: hold first, then correction
        run(1'b0, 1'b1, 1'b1, 2);
        run(1'b1, 1'b1, 1'b1, 2);
        // Reset beats load and enable
        run(1'b1, 1'b1, 1'b0, 3);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 32'h7);
        run(1'b1, 1'b1, 1'b0, 2);

        // N=32 Johnson period: exactly one wrap in 64 steps
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        wraps32 = 0;
        run(1'b1, 1'b1, 1'b0, 64);
        @(posedge clk);
        #2;
        check("wraps32_per_period", 64'(wraps32), 64'd1);

        // Random mix
        mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load = ($urandom_range(0, 7) == 0);
            lv4  = $urandom;
            lv32 = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                lv4  = seq_val($urandom_range(0, seq_len(4, mode) - 1), 4, mode);
                lv32 = seq_val($urandom_range(0, seq_len(32, mode) - 1), 32, mode);
            end
            drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), mode, load, lv4, lv32);
        end

        @(posedge clk);
        #2;
        check("sb4_drained", 64'(sb4.size()), 64'd0);
        check("sb32_drained", 64'(sb32.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/twisted_ring_counter.md
Name: twisted_ring_counter

Overview:
Parametrised shift-register counter generalising the fixed Johnson counter. Runtime-selectable Johnson (2N states) or ring (N states) sequence, up/down direction, count enable, parallel load, self-correction of illegal states, a wrap pulse and a decoded phase index. Used as a low-glitch phase/sequence generator feeding decoders and timing strobes elsewhere in the design.

Parameters:
N, 4, counter width in flip-flops; legal range N >= 2
PW, $clog2(2*N), phase index width (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low
en  input  1  count enable
up  input  1  direction: 1 = shift toward MSB, 0 = shift toward LSB
mode  input  1  0 = Johnson, 1 = ring
load  input  1  parallel load strobe
load_val  input  N  value to load
Q  output  N  counter state (registered)
phase  output  PW  decoded position of Q in the current sequence (combinational from Q and mode)
wrap  output  1  one-cycle pulse, registered
illegal  output  1  one-cycle pulse, registered: an illegal state was replaced by START

Behaviour:
- All state updates only on rising clk. No asynchronous paths.
- START = all-zeros in Johnson mode; {0..01} (bit 0 set) in ring mode.
- Legal states:
  - Johnson: the 2N patterns reachable from START.
  - Ring: exactly one bit set.
- Step functions:
  - Johnson up: Q <= {Q[N-2:0], ~Q[N-1]}
  - Johnson down: Q <= {~Q[0], Q[N-1:1]}
  - Ring up: Q <= {Q[N-2:0], Q[N-1]}
  - Ring down: Q <= {Q[0], Q[N-1:1]}
- Priority per edge, highest first: reset > load > correction > count > hold.
- Reset (rst=0 at edge): Q <= START for the mode sampled that cycle; wrap <= 0; illegal <= 0.
- Load (load=1):
  - load_val legal for the current mode: Q <= load_val, illegal <= 0.
  - load_val illegal: Q <= START, illegal <= 1.
  - wrap <= 0. Load ignores en.
- Correction: en=1, no load, Q illegal for the current mode: Q <= START, illegal <= 1, wrap <= 0.
- Count: en=1, Q legal: Q <= step(Q). wrap <= 1 iff the new Q == START (either direction); illegal <= 0.
- Hold: en=0 and no load: Q unchanged, wrap <= 0, illegal <= 0.
- Mode change takes effect at the next edge. An illegal state is corrected only when en=1 or load=1.
- Phase decode:
  - Johnson: Q[N-1]=0 -> number of ones in Q; Q[N-1]=1 -> N + number of zeros.
  - Ring: index of the set bit.
  - Illegal Q: phase = 0.
- Latency: one cycle from any input to Q, wrap and illegal. Phase follows Q combinationally.

Test Plan:
- N=4, Johnson, up, en=1 after reset -> Q = 0000,0001,0011,0111,1111,1110,1100,1000,0000; phase 0..7 then 0; wrap high only in the cycle Q returns to 0000 (every 8 cycles).
- N=4, Johnson, down from 0000 -> 1000,1100,1110,1111,0111,0011,0001,0000; wrap on the 8th step; toggle en=0 mid-sequence -> Q holds, no pulses.
- N=4, ring, up from reset -> 0001,0010,0100,1000,0001; wrap every 4 cycles. Down from 0001 -> 1000.
- Load 0101 in Johnson mode -> Q=0000, illegal=1 for one cycle. Load 0111 -> Q=0111, phase=3, illegal=0. Load and en both 1 -> load wins.
- Switch mode 0->1 while Q=0011, en=1 -> next Q=0001, illegal=1. With en=0 -> Q stays 0011, phase=0, no pulse until en rises.
- Assert rst=0 mid-count with en=1, load=1 -> next edge Q=START, wrap=illegal=0. No change before the edge (sync reset). Repeat with N=32 Johnson: full 64-cycle period, single wrap.
